// File: rtl/traffic_pkg.sv
// Shared types and constants for the traffic phase controller.
package traffic_pkg;

  typedef enum logic [1:0] {
    WINK,
    GREEN,
    ALL_RED,
    MANUAL
  } state_t;

  localparam logic [3:0] BLANK_DIGIT = 4'hF;

  // Elaboration-time conversion of a 0..99 duration into {tens, units} BCD.
  function automatic logic [7:0] to_bcd(input int unsigned v);
    logic [3:0] h;
    logic [3:0] l;
    h = 4'((v / 10) % 10);
    l = 4'(v % 10);
    return {h, l};
  endfunction

endpackage

// File: rtl/bcd_countdown.sv
// Two-digit BCD down-counter with load priority; floors at 01.
// digit_h/digit_l present the value the counter holds after the coming edge.
module bcd_countdown (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic       dec,
  output logic [3:0] digit_h,
  output logic [3:0] digit_l,
  output logic       at_one
);

  logic [3:0] tens;
  logic [3:0] units;
  logic       at_floor;

  assign at_one   = (tens == 4'd0) && (units == 4'd1);
  assign at_floor = (tens == 4'd0) && (units <= 4'd1);

  always_comb begin
    digit_h = tens;
    digit_l = units;
    if (load) begin
      {digit_h, digit_l} = load_val;
    end else if (dec && !at_floor) begin
      if (units == 4'd0) begin
        digit_l = 4'd9;
        digit_h = tens - 4'd1;
      end else begin
        digit_l = units - 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tens  <= '0;
      units <= '0;
    end else begin
      tens  <= digit_h;
      units <= digit_l;
    end
  end

endmodule

// File: rtl/traffic_phase_ctrl.sv
// Round-robin traffic light controller with wink idle, all-red clearance
// and manual override; every output is a flop loaded from next-state values.
module traffic_phase_ctrl
  import traffic_pkg::*;
#(
  parameter int unsigned NUM_PHASES  = 2,
  parameter int unsigned GREEN_TIME  = 30,
  parameter int unsigned ALLRED_TIME = 3,
  parameter int unsigned TICK_DIV    = 50000000
) (
  input  logic                    Clk,
  input  logic                    Rst,
  input  logic [NUM_PHASES-1:0]   Traffic,
  input  logic                    Manual_En,
  input  logic [NUM_PHASES-1:0]   Manual_Sel,
  output logic [NUM_PHASES-1:0]   Light_Green,
  output logic                    Wink,
  output logic [4*NUM_PHASES-1:0] Time_L,
  output logic [4*NUM_PHASES-1:0] Time_H
);

  localparam int unsigned     PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned     IW         = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1;
  localparam logic [PW-1:0]   PRESC_MAX  = PW'(TICK_DIV - 1);
  localparam logic [7:0]      GREEN_BCD  = to_bcd(GREEN_TIME);
  localparam logic [7:0]      ALLRED_BCD = to_bcd(ALLRED_TIME);

  state_t        state, state_nxt;
  logic [PW-1:0] presc;
  logic          tick;
  logic          entering;
  logic [IW-1:0] ptr, ptr_nxt, ptr_inc;
  logic [IW-1:0] phase, phase_nxt;
  logic [IW-1:0] pick;
  logic          found;
  logic          any_req;
  int unsigned   scan_idx;

  logic          tmr_load;
  logic [7:0]    tmr_load_val;
  logic          tmr_dec;
  logic [3:0]    digit_h, digit_l;
  logic          at_one;

  logic [NUM_PHASES-1:0]   lg_nxt;
  logic                    wink_nxt;
  logic [4*NUM_PHASES-1:0] th_nxt, tl_nxt;

  assign tick     = (presc == PRESC_MAX);
  assign any_req  = |Traffic;
  assign ptr_inc  = (phase == IW'(NUM_PHASES - 1)) ? '0 : phase + 1'b1;
  assign entering = (state_nxt != state);

  // First requesting phase at or after the pointer, wrapping around.
  always_comb begin
    pick     = '0;
    found    = 1'b0;
    scan_idx = 0;
    for (int unsigned i = 0; i < NUM_PHASES; i++) begin
      scan_idx = (32'(ptr) + i) % NUM_PHASES;
      if (!found && Traffic[IW'(scan_idx)]) begin
        pick  = IW'(scan_idx);
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    phase_nxt = phase;
    ptr_nxt   = ptr;
    if (Manual_En) begin
      state_nxt = MANUAL;
    end else begin
      case (state)
        WINK: begin
          if (tick && any_req) begin
            state_nxt = GREEN;
            phase_nxt = pick;
          end
        end
        GREEN: begin
          if (tick && at_one) begin
            state_nxt = ALL_RED;
            ptr_nxt   = ptr_inc;
          end
        end
        ALL_RED: begin
          if (tick && at_one) begin
            if (any_req) begin
              state_nxt = GREEN;
              phase_nxt = pick;
            end else begin
              state_nxt = WINK;
            end
          end
        end
        MANUAL:  state_nxt = ALL_RED;
        default: state_nxt = WINK;
      endcase
    end
  end

  assign tmr_load     = entering && (state_nxt == GREEN || state_nxt == ALL_RED);
  assign tmr_load_val = (state_nxt == GREEN) ? GREEN_BCD : ALLRED_BCD;
  assign tmr_dec      = tick && (state == GREEN || state == ALL_RED);

  bcd_countdown u_timer (
    .clk      (Clk),
    .rst      (Rst),
    .load     (tmr_load),
    .load_val (tmr_load_val),
    .dec      (tmr_dec),
    .digit_h  (digit_h),
    .digit_l  (digit_l),
    .at_one   (at_one)
  );

  // Output values decoded from the next state so they land with it.
  always_comb begin
    lg_nxt   = '0;
    wink_nxt = 1'b0;
    th_nxt   = {NUM_PHASES{BLANK_DIGIT}};
    tl_nxt   = {NUM_PHASES{BLANK_DIGIT}};
    case (state_nxt)
      WINK: wink_nxt = (state == WINK) ? (Wink ^ tick) : 1'b0;
      GREEN: begin
        lg_nxt[phase_nxt]          = 1'b1;
        th_nxt[4*phase_nxt +: 4]   = digit_h;
        tl_nxt[4*phase_nxt +: 4]   = digit_l;
      end
      ALL_RED: begin
        th_nxt = {NUM_PHASES{digit_h}};
        tl_nxt = {NUM_PHASES{digit_l}};
      end
      MANUAL: begin
        if ($onehot(Manual_Sel)) lg_nxt = Manual_Sel;
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state       <= WINK;
      presc       <= '0;
      ptr         <= '0;
      phase       <= '0;
      Light_Green <= '0;
      Wink        <= 1'b0;
      Time_H      <= {NUM_PHASES{BLANK_DIGIT}};
      Time_L      <= {NUM_PHASES{BLANK_DIGIT}};
    end else begin
      state       <= state_nxt;
      presc       <= (entering || tick) ? '0 : presc + 1'b1;
      ptr         <= ptr_nxt;
      phase       <= phase_nxt;
      Light_Green <= lg_nxt;
      Wink        <= wink_nxt;
      Time_H      <= th_nxt;
      Time_L      <= tl_nxt;
    end
  end

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Scoreboard bench for traffic_phase_ctrl with short timings (N=2, G=5, A=2, D=4).
module tb_traffic_phase_ctrl;

  logic       Clk = 1'b0;
  logic       Rst = 1'b0;
  logic [1:0] Traffic = 2'b00;
  logic       Manual_En = 1'b0;
  logic [1:0] Manual_Sel = 2'b00;
  logic [1:0] Light_Green;
  logic       Wink;
  logic [7:0] Time_L;
  logic [7:0] Time_H;

  typedef struct packed {
    logic [1:0] lg;
    logic       wk;
    logic [7:0] th;
    logic [7:0] tl;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  traffic_phase_ctrl #(
    .NUM_PHASES  (2),
    .GREEN_TIME  (5),
    .ALLRED_TIME (2),
    .TICK_DIV    (4)
  ) dut (
    .Clk         (Clk),
    .Rst         (Rst),
    .Traffic     (Traffic),
    .Manual_En   (Manual_En),
    .Manual_Sel  (Manual_Sel),
    .Light_Green (Light_Green),
    .Wink        (Wink),
    .Time_L      (Time_L),
    .Time_H      (Time_H)
  );

  always #5 Clk = ~Clk;

  // Expected outputs; a negative seconds value means blank digits.
  function automatic exp_t mk(input logic [1:0] lg, input logic wk, input int s0, input int s1);
    exp_t e;
    e.lg      = lg;
    e.wk      = wk;
    e.th[3:0] = (s0 < 0) ? 4'hF : 4'(s0 / 10);
    e.tl[3:0] = (s0 < 0) ? 4'hF : 4'(s0 % 10);
    e.th[7:4] = (s1 < 0) ? 4'hF : 4'(s1 / 10);
    e.tl[7:4] = (s1 < 0) ? 4'hF : 4'(s1 % 10);
    return e;
  endfunction

  task automatic cyc(input exp_t e);
    sb.push_back(e);
    @(negedge Clk);
  endtask

  task automatic green(input int p);
    for (int s = 5; s >= 1; s--)
      repeat (4) cyc(mk((p == 0) ? 2'b01 : 2'b10, 1'b0, (p == 0) ? s : -1, (p == 1) ? s : -1));
  endtask

  task automatic allred();
    for (int s = 2; s >= 1; s--)
      repeat (4) cyc(mk(2'b00, 1'b0, s, s));
  endtask

  task automatic wink_pat(input int n, input logic [15:0] pat);
    for (int i = 0; i < n; i++) cyc(mk(2'b00, pat[i], -1, -1));
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s t=%0t got=%h expected=%h", name, $time, act, req);
    end
  endtask

  // Monitor: outputs are valid every cycle; compare whatever the stimulus queued.
  initial begin
    exp_t e;
    forever begin
      @(posedge Clk);
      #1;
      total++;
      if (!$onehot0(Light_Green)) begin
        bad++;
        $display("FAIL onehot0 t=%0t got=%b expected=at most one bit", $time, Light_Green);
      end
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("light_green", {6'd0, Light_Green}, {6'd0, e.lg});
        chk("wink", {7'd0, Wink}, {7'd0, e.wk});
        chk("time_h", Time_H, e.th);
        chk("time_l", Time_L, e.tl);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog t=%0t got=timeout expected=finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge Clk);
    // Reset, then idle wink: toggles on every 4th cycle.
    Rst = 1'b1;
    cyc(mk(2'b00, 1'b0, -1, -1));
    Rst = 1'b0;
    wink_pat(8, 16'h0078);

    // Single request on phase 0, then back to wink.
    Traffic = 2'b01;
    repeat (3) cyc(mk(2'b00, 1'b0, -1, -1));
    green(0);
    Traffic = 2'b00;
    allred();
    wink_pat(5, 16'h0010);

    // Both phases requesting, pointer restarted by reset.
    Traffic = 2'b11;
    Rst = 1'b1;
    cyc(mk(2'b00, 1'b0, -1, -1));
    Rst = 1'b0;
    repeat (3) cyc(mk(2'b00, 1'b0, -1, -1));
    green(0); allred();
    green(1); allred();
    green(0); allred();
    green(1); allred();

    // Manual override in the middle of the phase-0 green.
    repeat (4) cyc(mk(2'b01, 1'b0, 5, -1));
    repeat (2) cyc(mk(2'b01, 1'b0, 4, -1));
    Manual_En = 1'b1; Manual_Sel = 2'b10;
    cyc(mk(2'b10, 1'b0, -1, -1));
    cyc(mk(2'b10, 1'b0, -1, -1));
    Manual_Sel = 2'b11;
    cyc(mk(2'b00, 1'b0, -1, -1));
    Manual_Sel = 2'b01;
    cyc(mk(2'b01, 1'b0, -1, -1));
    Manual_Sel = 2'b00;
    cyc(mk(2'b00, 1'b0, -1, -1));
    Traffic = 2'b10; Manual_En = 1'b0;
    allred();
    repeat (4) cyc(mk(2'b10, 1'b0, -1, 5));
    repeat (2) cyc(mk(2'b10, 1'b0, -1, 4));

    // Reset wins over a simultaneous manual request mid-green.
    Rst = 1'b1; Manual_En = 1'b1; Manual_Sel = 2'b01;
    cyc(mk(2'b00, 1'b0, -1, -1));
    Rst = 1'b0; Manual_En = 1'b0; Traffic = 2'b00;
    wink_pat(4, 16'h0008);

    // Manual from wink, release gives full clearance then wink.
    Manual_En = 1'b1; Manual_Sel = 2'b01;
    cyc(mk(2'b01, 1'b0, -1, -1));
    Manual_En = 1'b0;
    allred();
    cyc(mk(2'b00, 1'b0, -1, -1));

    @(negedge Clk);
    chk("queue_drained", 8'(sb.size()), 8'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/traffic_phase_ctrl.md
TRAFFIC_PHASE_CTRL -- requirements
Module: traffic_phase_ctrl

Interface
REQ-001 SHALL have parameter NUM_PHASES, default 2, number of approach phases (legal 2..8).
REQ-002 SHALL have parameter GREEN_TIME, default 30, green duration in seconds (legal 1..99).
REQ-003 SHALL have parameter ALLRED_TIME, default 3, all-red clearance in seconds (legal 1..99).
REQ-004 SHALL have parameter TICK_DIV, default 50000000, Clk cycles per second (legal >=1).
REQ-005 SHALL have port Clk  input  1  single clock; all state changes on its rising edge.
REQ-006 SHALL have port Rst  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port Traffic  input  NUM_PHASES  per-phase vehicle-present sensor, level.
REQ-008 SHALL have port Manual_En  input  1  police/manual override request, level.
REQ-009 SHALL have port Manual_Sel  input  NUM_PHASES  phase to force green under override, one-hot.
REQ-010 SHALL have port Light_Green  output  NUM_PHASES  1 = phase green, 0 = red.
REQ-011 SHALL have port Wink  output  1  flashing-amber drive, all phases.
REQ-012 SHALL have port Time_L  output  4*NUM_PHASES  per-phase BCD units digit, phase i at [4i+3:4i].
REQ-013 SHALL have port Time_H  output  4*NUM_PHASES  per-phase BCD tens digit, same packing.

Function
REQ-014 SHALL implement states WINK, GREEN, ALL_RED, MANUAL; all outputs registered, changing one cycle after the edge that samples their cause.
REQ-015 SHALL generate a one-cycle tick every TICK_DIV cycles from a prescaler cleared on every state entry, so the first second of every state is full length.
REQ-016 In WINK: Light_Green all 0, Wink toggles on each tick, all digits 4'hF (blank).
REQ-017 WINK -> GREEN on a tick with any Traffic bit set; served phase = first requesting phase at or after the round-robin pointer, wrapping.
REQ-018 In GREEN: only Light_Green[p] = 1, Wink 0, phase p digits show remaining seconds GREEN_TIME down to 01, other phases blank.
REQ-019 GREEN duration SHALL be exactly GREEN_TIME*TICK_DIV cycles; Traffic changes during GREEN are ignored.
REQ-020 GREEN -> ALL_RED on the tick at which display reads 01; pointer := (p+1) mod NUM_PHASES.
REQ-021 In ALL_RED: Light_Green all 0, every phase's digits show remaining clearance ALLRED_TIME down to 01; duration ALLRED_TIME*TICK_DIV cycles.
REQ-022 ALL_RED ends on the tick at 01: to GREEN for first requesting phase from pointer (wrapping), else to WINK.
REQ-023 Manual_En = 1 SHALL enter MANUAL from any state on the next cycle; Light_Green = Manual_Sel if exactly one bit set, else all 0; digits blank; Wink 0.
REQ-024 Manual_En falling SHALL enter ALL_RED with full ALLRED_TIME clearance; round-robin pointer unchanged by MANUAL.
REQ-025 Manual_Sel changes while in MANUAL SHALL take effect the next cycle.
REQ-026 Timer SHALL be a two-digit BCD down-counter; units wrap 0 -> 9 with tens decrement; never below 01 while displayed.
REQ-027 At most one Light_Green bit SHALL be 1 in any cycle, in every state.

Reset
REQ-028 Rst SHALL dominate Manual_En and all other inputs when asserted simultaneously.
REQ-029 On Rst: state WINK, Light_Green 0, Wink 0, all digits 4'hF, pointer 0, prescaler 0, timer 00; applies equally mid-GREEN/ALL_RED/MANUAL.

Structure
REQ-030 Shared package traffic_pkg SHALL hold the state enum, BLANK_DIGIT = 4'hF and the binary-to-BCD constant conversion function for GREEN_TIME/ALLRED_TIME.
REQ-031 One sub-module bcd_countdown (load, tick-decrement, at-one flag, two BCD digits) SHALL be instantiated once and shared by GREEN and ALL_RED.

Verification (NUM_PHASES=2, GREEN_TIME=5, ALLRED_TIME=2, TICK_DIV=4)
REQ-032 Rst 1 cycle, Traffic=00 -> Light_Green=00, all digits F, Wink toggles every 4 cycles.
REQ-033 Traffic=01 -> phase 0 green at next tick, Time_H0/Time_L0 = 0/5..0/1 over 20 cycles, then 8 cycles all-red showing 02, 01 on both phases, then WINK.
REQ-034 Traffic=11 held -> green sequence 0,1,0,1 with 20-cycle greens separated by 8-cycle all-red.
REQ-035 Manual_En=1, Manual_Sel=10 mid-phase-0 green -> next cycle Light_Green=10, digits F; Manual_Sel=11 -> Light_Green=00; release -> 8-cycle all-red, then phase 1 served if requesting.
REQ-036 Rst asserted with Manual_En=1 mid-green -> next cycle full reset values; one-hot-or-zero Light_Green assertion holds throughout all scenarios.
